// File: rtl/imem_responder.sv
// Word-addressed instruction memory: LOAD fills it over a valid/ready port, RUN serves PC fetches (IMEM_PARITY_EN adds per-word parity).
// Latency: fetch address in cycle N -> Instruction/addr_fault registered in cycle N+1.
// Backpressure: load_ready drops in RUN, in reset and once DEPTH words are held; loads are never dropped silently.
module imem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       IM_Address,
    output logic [DATA_W-1:0] Instruction,
    output logic              addr_fault,
    output logic              cpu_ready,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              reload,
    output logic [ADDR_W:0]   word_count
`ifdef IMEM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {LOAD, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic              beat;
    logic              in_range;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  mem [DEPTH];

    // wr_ptr MSB set means wr_ptr == DEPTH, i.e. the memory is full.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        load_ready = 1'b0;
        beat       = 1'b0;
        case (state_q)
            LOAD: begin
                load_ready = !reset && !wr_ptr_q[ADDR_W];
                beat       = load_valid && load_ready;
                if (beat) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (load_last || (&wr_ptr_q[ADDR_W-1:0]))
                        state_d = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Contents survive reset so a warm restart can rerun the same program.
    always_ff @(posedge clk) begin
        if (beat) begin
`ifdef IMEM_PARITY_EN
            mem[wr_ptr_q[ADDR_W-1:0]] <= {^load_data, load_data};
`else
            mem[wr_ptr_q[ADDR_W-1:0]] <= load_data;
`endif
        end
    end

    // Full 32-bit compare so high addresses never alias onto loaded words.
    assign in_range = IM_Address < 32'(wr_ptr_q);
    assign rd_word  = mem[IM_Address[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset || state_q != RUN || reload) begin
            Instruction <= '0;
            addr_fault  <= 1'b0;
`ifdef IMEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else if (in_range) begin
            Instruction <= rd_word[DATA_W-1:0];
            addr_fault  <= 1'b0;
`ifdef IMEM_PARITY_EN
            parity_err  <= (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`endif
        end else begin
            Instruction <= '0;
            addr_fault  <= 1'b1;
`ifdef IMEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end
    end

    assign cpu_ready  = (state_q == RUN);
    assign word_count = wr_ptr_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a default-depth instance plus a 4-word instance for the auto-RUN boundary.
module tb_imem_responder;

    logic        clk;
    logic        reset;

    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
    logic        cpu_ready;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        last;
    logic        reload;
    logic [8:0]  wcount;

    logic [31:0] s_addr;
    logic [31:0] s_instr;
    logic        s_fault;
    logic        s_cpu_ready;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_reload;
    logic [2:0]  s_wcount;

`ifdef IMEM_PARITY_EN
    logic        perr;
    logic        s_perr;
`endif

    int total = 0;
    int bad   = 0;

    imem_responder u_dut (
        .clk         (clk),
        .reset       (reset),
        .IM_Address  (addr),
        .Instruction (instr),
        .addr_fault  (fault),
        .cpu_ready   (cpu_ready),
        .load_valid  (valid),
        .load_ready  (ready),
        .load_data   (data),
        .load_last   (last),
        .reload      (reload),
        .word_count  (wcount)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err  (perr)
`endif
    );

    imem_responder #(.ADDR_W(2), .DATA_W(32)) u_small (
        .clk         (clk),
        .reset       (reset),
        .IM_Address  (s_addr),
        .Instruction (s_instr),
        .addr_fault  (s_fault),
        .cpu_ready   (s_cpu_ready),
        .load_valid  (s_valid),
        .load_ready  (s_ready),
        .load_data   (s_data),
        .load_last   (s_last),
        .reload      (s_reload),
        .word_count  (s_wcount)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err  (s_perr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] words [4];

    initial begin
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        words[3] = 32'h44444444;

        reset = 1'b1;
        addr = '0; valid = 1'b0; data = '0; last = 1'b0; reload = 1'b0;
        s_addr = '0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_reload = 1'b0;
        tick();
        tick();
        check("rst_instr", instr, 0);
        check("rst_fault", fault, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_wcount", wcount, 0);
        check("rst_load_ready", ready, 0);
        reset = 1'b0;
        #1;
        check("idle_load_ready", ready, 1);

        // small instance: fill to DEPTH without load_last, keep offering
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h100 + i;
            tick();
            if (i == 2) check("small_cpu_ready_3", s_cpu_ready, 0);
        end
        check("small_auto_run", s_cpu_ready, 1);
        check("small_wcount4", s_wcount, 4);
        check("small_ready_full", s_ready, 0);
        s_data = 32'h999;
        tick();
        check("small_5th_rejected", s_wcount, 4);
        s_valid = 1'b0;
        s_addr  = 32'd3;
        tick();
        check("small_rd3", s_instr, 32'h103);
        s_addr = 32'd4;
        tick();
        check("small_rd4_fault", s_fault, 1);
        check("small_rd4_instr", s_instr, 0);

        // main instance: 4-word program, address driven during LOAD must be ignored
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            data  = words[i];
            last  = (i == 3);
            addr  = 32'd0;
            tick();
            if (i == 2) check("load_cpu_ready", cpu_ready, 0);
        end
        valid = 1'b0; last = 1'b0;
        check("load_wcount", wcount, 4);
        check("load_cpu_ready_run", cpu_ready, 1);
        check("load_ready_run", ready, 0);
        check("load_instr_zero", instr, 0);

        for (int i = 0; i < 4; i++) begin
            addr = i;
            tick();
            check($sformatf("rd%0d_instr", i), instr, words[i]);
            check($sformatf("rd%0d_fault", i), fault, 0);
        end
        addr = 32'd4;
        tick();
        check("rd4_instr", instr, 0);
        check("rd4_fault", fault, 1);
        addr = 32'h80000002;
        tick();
        check("rd_hi_instr", instr, 0);
        check("rd_hi_fault", fault, 1);
        addr = 32'h00000100;
        tick();
        check("rd_alias_fault", fault, 1);
        addr = 32'd2;
        tick();
        check("rd_recover_instr", instr, 32'h33333333);
        check("rd_recover_fault", fault, 0);

        valid = 1'b1; data = 32'h0BAD0BAD;
        tick();
        valid = 1'b0;
        check("run_ignores_load", wcount, 4);

        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_cpu_ready", cpu_ready, 0);
        check("reload_wcount", wcount, 0);
        check("reload_instr", instr, 0);
        check("reload_fault", fault, 0);
        check("reload_ready", ready, 1);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_in_load", cpu_ready, 0);

        valid = 1'b1; data = 32'hDEADBEEF; last = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0;
        check("one_word_wcount", wcount, 1);
        check("one_word_cpu_ready", cpu_ready, 1);
        addr = 32'd0;
        tick();
        check("one_word_rd0", instr, 32'hDEADBEEF);
        addr = 32'd1;
        tick();
        check("one_word_rd1_fault", fault, 1);
        check("one_word_rd1_instr", instr, 0);

        // reset mid-load with load_valid held high
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        valid = 1'b1; data = 32'hA0A0A0A0;
        tick();
        data = 32'hA1A1A1A1;
        tick();
        check("midload_wcount2", wcount, 2);
        data  = 32'hFFFFFFFF;
        reset = 1'b1;
        #1;
        check("midrst_ready_comb", ready, 0);
        tick();
        check("midrst_wcount", wcount, 0);
        check("midrst_ready", ready, 0);
        tick();
        reset = 1'b0;
        valid = 1'b0;
        #1;
        check("postrst_ready", ready, 1);
        check("postrst_cpu_ready", cpu_ready, 0);
        valid = 1'b1; data = 32'hCAFEF00D; last = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0;
        check("postrst_wcount", wcount, 1);
        addr = 32'd0;
        tick();
        check("postrst_rd0", instr, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Word-addressed instruction memory. It is the responder end of the program-counter fetch interface.
- Takes the word address driven by the PC register and returns the instruction word.
- Provides a valid/ready load port so a testbench or boot loader can write the program before execution starts.
- Sits between the PC and the decoder/register-file stage of the single-cycle CPU.

Parameters:
- ADDR_W, 8, log2 of memory depth in 32-bit words; DEPTH = 2**ADDR_W.
- DATA_W, 32, instruction word width.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- IM_Address  input  32  word address from PC (word index, not a byte address).
- Instruction  output  DATA_W  fetched instruction, registered.
- addr_fault  output  1  registered; high when the fetched address is outside the loaded program.
- cpu_ready  output  1  high in RUN; the CPU must hold PC in reset while this is low.
- load_valid  input  1  load beat offered.
- load_ready  output  1  load beat can be accepted.
- load_data  input  DATA_W  instruction word to store.
- load_last  input  1  marks the final word of the program; qualified by a beat.
- reload  input  1  single-cycle request to return to LOAD from RUN.
- word_count  output  ADDR_W+1  number of words loaded.

Behaviour:
- States: LOAD, RUN. Reset has priority over every other input in the same cycle.
- Reset, including mid-load or mid-run:
  - state=LOAD, wr_ptr=0, word_count=0.
  - Instruction=0, addr_fault=0, cpu_ready=0.
  - Memory contents are not cleared.
- LOAD:
  - load_ready = (wr_ptr < DEPTH).
  - A beat is load_valid & load_ready. On a beat: mem[wr_ptr] <= load_data, wr_ptr++, word_count++.
  - Transition to RUN on the clock edge that accepts a beat with load_last=1, or the beat that makes wr_ptr==DEPTH.
  - Instruction holds 0 and addr_fault holds 0 during LOAD.
  - IM_Address is ignored.
- RUN:
  - cpu_ready=1, load_ready=0; load_valid is ignored.
  - Each posedge: if the full 32-bit IM_Address < word_count, Instruction <= mem[IM_Address] and addr_fault <= 0.
  - Otherwise Instruction <= 0 (NOP) and addr_fault <= 1.
  - Read latency is exactly 1 cycle: the address presented in cycle N gives Instruction/addr_fault in cycle N+1.
  - The comparison uses all 32 address bits, so there is no aliasing or wrap of high addresses.
- reload in RUN:
  - Next state is LOAD; wr_ptr=0, word_count=0, cpu_ready=0.
  - Instruction and addr_fault clear to 0.
  - reload in LOAD has no effect.
- Zero-length program is not possible: the first accepted beat always stores a word.
- Boundary cases:
  - load_last on the DEPTH-th beat produces a single transition.
  - A beat offered when wr_ptr==DEPTH is not accepted, because load_ready=0.
- word_count saturates at DEPTH and never wraps.
- The memory has a single write port and a single read port. Writes occur only in LOAD and reads only in RUN, so no read/write collision is possible.

Optional Feature:
- Macro IMEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed from load_data at write time.
  - On every RUN read of an in-range address, the stored parity is recomputed. A mismatch drives the extra output parity_err high for that cycle, aligned with Instruction.
  - parity_err is 0 on reset, in LOAD, and for out-of-range reads.
- When undefined: parity_err port and parity storage are absent. Memory width is DATA_W.

Test Plan:
- Reset, then load 4 words (0x11111111, 0x22222222, 0x33333333, 0x44444444) with load_last on the 4th -> word_count=4, cpu_ready=1 on the next cycle, load_ready=0.
- RUN with IM_Address=0,1,2,3 on consecutive cycles -> Instruction=0x11111111..0x44444444 one cycle later each, addr_fault=0.
- RUN with IM_Address=4, then 0x80000002 -> Instruction=0 and addr_fault=1 for both, one cycle later.
- With ADDR_W=2, load 4 words without load_last, then hold load_valid -> auto-RUN after the 4th beat, the 5th beat is not accepted, word_count=4.
- reload pulse in RUN, then load 1 word 0xDEADBEEF with load_last -> word_count=1; IM_Address=0 gives 0xDEADBEEF; IM_Address=1 gives addr_fault=1.
- Assert reset mid-load after 2 beats, with load_valid held high -> word_count=0 and load_ready=0 during reset. After reset releases: load_ready=1, state=LOAD, and the first accepted beat writes address 0.
